// File: rtl/canvas_pkg.sv
// ---------------------------------------------------------------------------
// canvas_pkg
//   Shared constants and the controller state encoding for the tile canvas
//   slice (canvas_access_ctrl and its cell_sweep counter).
//
//   CANVAS_ADDR_W  cell address width, address = {y[4:0], x[4:0]}
//   CANVAS_CELLS   cells per 32x32 tile
//   canvas_state_t controller states, 3-bit encoding
//                  IDLE=0, DRAW=1, SCAN_RD=2, SCAN_OUT=3, CLEAR=4
// ---------------------------------------------------------------------------
package canvas_pkg;

    localparam int CANVAS_ADDR_W = 10;
    localparam int CANVAS_CELLS  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAW     = 3'd1,
        ST_SCAN_RD  = 3'd2,
        ST_SCAN_OUT = 3'd3,
        ST_CLEAR    = 3'd4
    } canvas_state_t;

endpackage

// File: rtl/cell_sweep.sv
// ---------------------------------------------------------------------------
// cell_sweep
//   Cell address counter shared by the commit scan and the clear sweep.
//   Counts 0..CELLS-1 and wraps back to 0 on the step taken at the last cell,
//   so a finished sweep always leaves the counter ready for the next one.
//
//   clk    in   system clock
//   rst    in   asynchronous active-high reset, counter -> 0
//   en     in   advance one cell this cycle
//   clr    in   force counter to 0 (has priority over en)
//   count  out  current cell address
//   last   out  count is cell CELLS-1
// ---------------------------------------------------------------------------
module cell_sweep
    import canvas_pkg::*;
#(
    parameter int ADDR_W = CANVAS_ADDR_W,
    parameter int CELLS  = CANVAS_CELLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    assign last = (count == ADDR_W'(CELLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/canvas_access_ctrl.sv
// ---------------------------------------------------------------------------
// canvas_access_ctrl
//   Owns the single-port 32x32x1 tile bitmap RAM and arbitrates it between
//   pen writes (IDLE/DRAW pass-through), a commit scan that streams every
//   cell to the recognizer (SCAN_RD/SCAN_OUT), and a clear sweep (CLEAR).
//   A commit always runs into a clear; leaving CLEAR pulses end_of_editing.
//
//   clk, rst        clock, asynchronous active-high reset
//   editing         session-active flag, IDLE -> DRAW
//   draw_we/addr/data  pen write port, forwarded only in IDLE and DRAW
//   clear_req       pulse: discard the tile (IDLE/DRAW only)
//   commit_req      pulse: commit the tile (DRAW only)
//   ram_we/addr/wdata  RAM command, ram_rdata returns one cycle after addr
//   scan_valid/ready/addr/data/last  scan beat stream, one beat per cell
//   end_of_editing  pulse in the first IDLE cycle after a clear
//   busy            RAM owned by scan or clear
//   draw_drop       pulse: a pen write arrived while busy and was discarded
// ---------------------------------------------------------------------------
module canvas_access_ctrl
    import canvas_pkg::*;
#(
    parameter int ADDR_W       = CANVAS_ADDR_W,
    parameter int CELLS        = CANVAS_CELLS,
    parameter int IDLE_TIMEOUT = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              editing,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic              draw_data,
    input  logic              clear_req,
    input  logic              commit_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    input  logic              ram_rdata,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_data,
    output logic              scan_last,
    output logic              end_of_editing,
    output logic              busy,
    output logic              draw_drop
);

    localparam int IW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

    canvas_state_t     state, state_nx;
    logic [IW-1:0]     idle_cnt;
    logic              idle_hit;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              sweep_last;
    logic              sweep_en;
    logic              sweep_clr;
    logic              held_q;
    logic              data_q;
    logic              eoe_q;

    assign idle_hit       = (idle_cnt == IW'(IDLE_TIMEOUT - 1));
    assign end_of_editing = eoe_q;

    cell_sweep #(
        .ADDR_W (ADDR_W),
        .CELLS  (CELLS)
    ) u_sweep (
        .clk   (clk),
        .rst   (rst),
        .en    (sweep_en),
        .clr   (sweep_clr),
        .count (sweep_cnt),
        .last  (sweep_last)
    );

    // Next state and all RAM / stream outputs.
    always_comb begin
        state_nx   = state;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = 1'b0;
        scan_valid = 1'b0;
        scan_addr  = '0;
        scan_data  = 1'b0;
        scan_last  = 1'b0;
        busy       = 1'b0;
        draw_drop  = 1'b0;
        sweep_en   = 1'b0;
        sweep_clr  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ram_we    = draw_we;
                ram_addr  = draw_addr;
                ram_wdata = draw_data;
                sweep_clr = 1'b1;
                // A discard request outranks starting a session.
                if (clear_req)    state_nx = ST_CLEAR;
                else if (editing) state_nx = ST_DRAW;
            end
            ST_DRAW: begin
                ram_we    = draw_we;
                ram_addr  = draw_addr;
                ram_wdata = draw_data;
                sweep_clr = 1'b1;
                if (clear_req)                  state_nx = ST_CLEAR;
                else if (commit_req || idle_hit) state_nx = ST_SCAN_RD;
            end
            ST_SCAN_RD: begin
                busy      = 1'b1;
                draw_drop = draw_we;
                ram_addr  = sweep_cnt;
                state_nx  = ST_SCAN_OUT;
            end
            ST_SCAN_OUT: begin
                busy       = 1'b1;
                draw_drop  = draw_we;
                ram_addr   = sweep_cnt;
                scan_valid = 1'b1;
                scan_addr  = sweep_cnt;
                // First SCAN_OUT cycle takes the fresh RAM word; while stalled
                // the captured copy is presented so the beat cannot change.
                scan_data  = held_q ? data_q : ram_rdata;
                scan_last  = sweep_last;
                if (scan_ready) begin
                    sweep_en = 1'b1;
                    state_nx = sweep_last ? ST_CLEAR : ST_SCAN_RD;
                end
            end
            ST_CLEAR: begin
                busy      = 1'b1;
                draw_drop = draw_we;
                ram_we    = 1'b1;
                ram_wdata = 1'b0;
                ram_addr  = sweep_cnt;
                sweep_en  = 1'b1;
                if (sweep_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Pen-idle counter: only meaningful in DRAW, restarts on every pen write,
    // and sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != ST_DRAW || draw_we) begin
            idle_cnt <= '0;
        end else if (idle_cnt != {IW{1'b1}}) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // Beat data hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= 1'b0;
            data_q <= 1'b0;
        end else begin
            held_q <= (state == ST_SCAN_OUT);
            if (state == ST_SCAN_OUT) data_q <= scan_data;
        end
    end

    // Registered so the pulse lands in the first IDLE cycle after the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) eoe_q <= 1'b0;
        else     eoe_q <= (state == ST_CLEAR) && sweep_last;
    end

endmodule

// File: tb/tb_canvas_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_canvas_access_ctrl
//   Directed sequence with randomized pen writes and scan_ready. A bench RAM
//   serves the DUT; a separate golden tile (gold[]) records what the tile
//   should hold from the pen/clear rules alone and scan beats are compared
//   against it.
// ---------------------------------------------------------------------------
module tb_canvas_access_ctrl;

    localparam int AW = 10;
    localparam int N  = 1024;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          editing, draw_we, draw_data, clear_req, commit_req;
    logic [AW-1:0] draw_addr;
    logic          ram_we, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic          scan_valid, scan_ready, scan_data, scan_last;
    logic [AW-1:0] scan_addr;
    logic          end_of_editing, busy, draw_drop;

    logic mem [N] = '{default: 1'b0};
    bit   gold [N];
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    canvas_access_ctrl #(
        .ADDR_W(AW), .CELLS(N), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .editing(editing),
        .draw_we(draw_we), .draw_addr(draw_addr), .draw_data(draw_data),
        .clear_req(clear_req), .commit_req(commit_req),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_addr(scan_addr), .scan_data(scan_data), .scan_last(scan_last),
        .end_of_editing(end_of_editing), .busy(busy), .draw_drop(draw_drop)
    );

    // Single-port RAM, synchronous read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gold_clear();
        for (int i = 0; i < N; i++) gold[i] = 1'b0;
    endtask

    // One pen write in IDLE/DRAW: forwarded to the RAM in the same cycle.
    task automatic draw_write(input logic [AW-1:0] a, input logic d);
        draw_we = 1'b1; draw_addr = a; draw_data = d;
        #1;
        chk("pass_we",    ram_we,    1);
        chk("pass_addr",  ram_addr,  a);
        chk("pass_wdata", ram_wdata, d);
        chk("pass_drop",  draw_drop, 0);
        gold[a] = d;
        tick();
        draw_we = 1'b0;
    endtask

    task automatic random_writes(input int n);
        for (int i = 0; i < n; i++)
            draw_write(AW'($urandom_range(N - 1)), 1'($urandom_range(1)));
    endtask

    // Consume scan beats from the current cycle on. bp_beat: beat held off
    // for exactly 5 valid cycles. stop_at: return while that beat is offered.
    task automatic scan_phase(input int bp_beat, input int stop_at);
        int            nbeat = 0;
        int            bpc   = 0;
        int            cyc   = 0;
        bit            done  = 0;
        bit            stop  = 0;
        bit            pend  = 0;
        bit            force0;
        logic [AW-1:0] pa    = '0;
        logic          pd    = 1'b0;
        while (!done && !stop && cyc < 8000) begin
            force0     = (nbeat == bp_beat) && (bpc < 5);
            scan_ready = force0 ? 1'b0 : ($urandom_range(3) != 0);
            #1;
            if (pend) begin
                chk("hold_valid", scan_valid, 1);
                chk("hold_addr",  scan_addr,  pa);
                chk("hold_data",  scan_data,  pd);
            end
            if (scan_valid) begin
                chk("beat_addr", scan_addr, nbeat);
                chk("beat_data", scan_data, gold[nbeat]);
                chk("beat_last", scan_last, (nbeat == N - 1));
                if (nbeat == stop_at) begin
                    stop = 1;
                end else begin
                    if (force0) bpc++;
                    if (scan_ready) begin
                        if (nbeat == N - 1) done = 1;
                        nbeat++;
                    end
                end
            end
            pend = scan_valid && !scan_ready;
            pa   = scan_addr;
            pd   = scan_data;
            cyc++;
            if (!stop) tick();
        end
        scan_ready = 1'b0;
        if (!done && !stop) chk("scan_timeout", 0, 1);
        if (!stop) chk("beat_count", nbeat, N);
        if (bp_beat >= 0) chk("bp_cycles", bpc, 5);
    endtask

    // Expects to be entered in the first CLEAR cycle. inject: sweep index at
    // which a pen write to cell 5 (already cleared) must be dropped.
    task automatic clear_phase(input int inject);
        for (int i = 0; i < N; i++) begin
            clear_req = (i == 10);
            if (i == inject) begin
                draw_we = 1'b1; draw_addr = AW'(5); draw_data = 1'b1;
            end
            #1;
            chk("clr_we",    ram_we,         1);
            chk("clr_wdata", ram_wdata,      0);
            chk("clr_addr",  ram_addr,       i);
            chk("clr_busy",  busy,           1);
            chk("clr_noscan", scan_valid,    0);
            chk("clr_eoe",   end_of_editing, 0);
            chk("clr_drop",  draw_drop,      (i == inject));
            tick();
            draw_we = 1'b0; clear_req = 1'b0;
        end
        #1;
        chk("eoe_pulse", end_of_editing, 1);
        chk("idle_busy", busy,           0);
        tick();
        #1;
        chk("eoe_single", end_of_editing, 0);
        gold_clear();
    endtask

    task automatic readback_zero();
        int nz = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 1'b0) nz++;
        chk("readback_zero", nz, 0);
    endtask

    initial begin
        rst = 1'b1; editing = 1'b0; draw_we = 1'b0; draw_addr = '0;
        draw_data = 1'b0; clear_req = 1'b0; commit_req = 1'b0; scan_ready = 1'b0;
        gold_clear();
        #12;
        chk("rst_ram_we", ram_we,         0);
        chk("rst_valid",  scan_valid,     0);
        chk("rst_busy",   busy,           0);
        chk("rst_eoe",    end_of_editing, 0);
        chk("rst_drop",   draw_drop,      0);
        tick();
        rst = 1'b0;
        tick();

        // 1: IDLE pass-through, commit ignored in IDLE
        draw_write(AW'('h123), 1'b1);
        random_writes(4);
        gold[AW'('h123)] = 1'b1;
        draw_write(AW'('h123), 1'b1);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        #1;
        chk("idle_commit_ignored", busy, 0);

        // 2: auto-commit after 16 quiet cycles, backpressure on beat 7
        editing = 1'b1;
        tick();
        random_writes(6);
        draw_write(AW'('h123), 1'b1);
        // Idle count reads 15 during the 16th quiet cycle, which decides the
        // move; the 17th cycle is SCAN_RD.
        for (int k = 1; k <= TO; k++) begin
            #1;
            chk("autocommit_early", busy, 0);
            tick();
        end
        editing = 1'b0;
        #1;
        chk("autocommit_busy", busy,     1);
        chk("scanrd_we",       ram_we,   0);
        chk("scanrd_addr",     ram_addr, 0);
        scan_phase(7, -1);
        clear_phase(-1);
        readback_zero();

        // 4 + 5a: explicit commit with a write in the transition cycle,
        // dropped write during CLEAR
        editing = 1'b1;
        tick();
        random_writes(8);
        commit_req = 1'b1;
        draw_write(AW'('h2AA), 1'b1);
        commit_req = 1'b0;
        editing = 1'b0;
        #1;
        chk("commit_busy", busy, 1);
        scan_phase(-1, -1);
        clear_phase(300);
        readback_zero();

        // 5b: clear_req and commit_req together -> straight to CLEAR
        editing = 1'b1;
        tick();
        random_writes(5);
        clear_req = 1'b1; commit_req = 1'b1;
        #1;
        chk("prio_still_draw", busy, 0);
        tick();
        clear_req = 1'b0; commit_req = 1'b0; editing = 1'b0;
        clear_phase(-1);
        readback_zero();

        // 6: async reset at beat 500, RAM survives, fresh commit from 0
        editing = 1'b1;
        tick();
        random_writes(10);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0; editing = 1'b0;
        scan_phase(-1, 500);
        rst = 1'b1;
        #1;
        chk("arst_valid", scan_valid,     0);
        chk("arst_busy",  busy,           0);
        chk("arst_we",    ram_we,         0);
        chk("arst_addr",  scan_addr,      0);
        chk("arst_eoe",   end_of_editing, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("arst_hold_eoe", end_of_editing, 0);
        end
        rst = 1'b0;
        tick();
        #1;
        chk("post_rst_idle", busy, 0);
        chk("post_rst_eoe",  end_of_editing, 0);
        editing = 1'b1;
        tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0; editing = 1'b0;
        #1;
        chk("restart_busy", busy,     1);
        chk("restart_addr", ram_addr, 0);
        scan_phase(-1, -1);
        clear_phase(-1);
        readback_zero();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
